// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        KILL = 3'd4
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [63:0] pc_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one imem request in flight and hands
// returned instructions to the FD register, killing wrong-path fetches on redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter pc_t         ResetPc    = 64'h0000_0000_0000_0000,
    parameter int unsigned CountWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  redirect_valid_i,
    input  logic [63:0]           redirect_pc_i,
    output logic                  imem_req_valid_o,
    output logic [63:0]           imem_req_addr_o,
    input  logic                  imem_req_ready_i,
    input  logic                  imem_rsp_valid_i,
    input  logic [31:0]           imem_rsp_data_i,
    output logic                  fd_valid_o,
    output logic [31:0]           fd_instruction_o,
    output logic [63:0]           fd_pc_o,
    input  logic                  fd_ready_i,
    output logic                  fd_flush_o,
    output logic [CountWidth-1:0] fetched_count_o
);

    fetch_state_t          state_q, state_d;
    pc_t                   pc_q, pc_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [31:0]           hold_instr_q, hold_instr_d;
    pc_t                   hold_pc_q, hold_pc_d;
    logic [CountWidth-1:0] count_q, count_d;

    pc_t  redirect_target;
    pc_t  pc_next;
    logic deliver;

    assign redirect_target = redirect_pc_i & ~pc_t'(INSTR_BYTES - 1);
    assign pc_next         = pc_q + pc_t'(INSTR_BYTES);

    // Redirect wins over everything, so it masks both request and delivery.
    always_comb begin
        imem_req_valid_o = 1'b0;
        fd_valid_o       = 1'b0;
        fd_instruction_o = imem_rsp_data_i;
        fd_pc_o          = pc_q;
        case (state_q)
            REQ:  imem_req_valid_o = !redirect_valid_i;
            WAIT: fd_valid_o       = imem_rsp_valid_i && !redirect_valid_i;
            HOLD: begin
                fd_valid_o       = hold_valid_q && !redirect_valid_i;
                fd_instruction_o = hold_instr_q;
                fd_pc_o          = hold_pc_q;
            end
            default: ;
        endcase
    end

    assign imem_req_addr_o = pc_q;
    assign fd_flush_o      = redirect_valid_i && reset_ni;
    assign fetched_count_o = count_q;
    assign deliver         = fd_valid_o && fd_ready_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        count_d      = deliver ? count_q + CountWidth'(1) : count_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_target;
                end else if (imem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_target;
                    state_d = imem_rsp_valid_i ? REQ : KILL;
                end else if (imem_rsp_valid_i) begin
                    if (fd_ready_i) begin
                        pc_d    = pc_next;
                        state_d = REQ;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_instr_d = imem_rsp_data_i;
                        hold_pc_d    = pc_q;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid_i) begin
                    pc_d         = redirect_target;
                    hold_valid_d = 1'b0;
                    state_d      = REQ;
                end else if (fd_ready_i) begin
                    pc_d         = pc_next;
                    hold_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            KILL: begin
                // The stale response still has to drain before a new request.
                if (redirect_valid_i) begin
                    pc_d = redirect_target;
                end
                if (imem_rsp_valid_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            pc_q         <= ResetPc;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against an
// instruction-stream reference model and a one-outstanding memory model.
module tb_fetch_ctrl;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_ni;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic [63:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        fd_valid_o;
    logic [31:0] fd_instruction_o;
    logic [63:0] fd_pc_o;
    logic        fd_ready_i;
    logic        fd_flush_o;
    logic [31:0] fetched_count_o;

    logic        w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_fd_valid;
    logic [31:0] w_fd_instr;
    logic [63:0] w_fd_pc;
    logic        w_fd_flush;
    logic [31:0] w_count;

    fetch_ctrl u_dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .fd_valid_o       (fd_valid_o),
        .fd_instruction_o (fd_instruction_o),
        .fd_pc_o          (fd_pc_o),
        .fd_ready_i       (fd_ready_i),
        .fd_flush_o       (fd_flush_o),
        .fetched_count_o  (fetched_count_o)
    );

    fetch_ctrl #(.ResetPc(WRAP_PC), .CountWidth(32)) u_dut_wrap (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .redirect_valid_i (1'b0),
        .redirect_pc_i    (64'h0),
        .imem_req_valid_o (w_req_valid),
        .imem_req_addr_o  (w_req_addr),
        .imem_req_ready_i (1'b1),
        .imem_rsp_valid_i (w_rsp_valid),
        .imem_rsp_data_i  (w_rsp_data),
        .fd_valid_o       (w_fd_valid),
        .fd_instruction_o (w_fd_instr),
        .fd_pc_o          (w_fd_pc),
        .fd_ready_i       (1'b1),
        .fd_flush_o       (w_fd_flush),
        .fetched_count_o  (w_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h00A0_0093;
    endfunction

    // Memory model state
    bit          mem_pend;
    logic [63:0] mem_addr;
    int          mem_lat;
    int          lat_fixed;
    bit          w_pend;
    logic [63:0] w_addr;
    int          w_seen;
    logic [63:0] w_addrs [2];

    // Reference model: the next instruction the front end must deliver
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;
    bit          prev_stall;

    // Samples of the last tick
    logic        s_req_valid, s_fd_valid, s_flush;
    logic [63:0] s_req_addr, s_fd_pc;
    logic [31:0] s_fd_instr, s_count;
    logic        w_s_fd_valid;
    logic [63:0] w_s_fd_pc;
    logic [31:0] w_s_fd_instr, w_s_count;

    task automatic tick(input bit redir, input logic [63:0] tgt, input bit fdr, input bit rdy);
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        fd_ready_i       = fdr;
        imem_req_ready_i = rdy;
        imem_rsp_valid_i = mem_pend && (mem_lat == 0);
        imem_rsp_data_i  = mem_fn(mem_addr);
        w_rsp_valid      = w_pend;
        w_rsp_data       = mem_fn(w_addr);
        #1;
        s_req_valid  = imem_req_valid_o;
        s_req_addr   = imem_req_addr_o;
        s_fd_valid   = fd_valid_o;
        s_fd_pc      = fd_pc_o;
        s_fd_instr   = fd_instruction_o;
        s_flush      = fd_flush_o;
        s_count      = fetched_count_o;
        w_s_fd_valid = w_fd_valid;
        w_s_fd_pc    = w_fd_pc;
        w_s_fd_instr = w_fd_instr;
        w_s_count    = w_count;

        check("flush", s_flush, redir);
        check("count", s_count, exp_cnt);
        if (redir) begin
            check("fd_vld_on_redirect", s_fd_valid, 0);
            check("req_vld_on_redirect", s_req_valid, 0);
        end
        if (s_req_valid) begin
            check("req_addr", s_req_addr, exp_pc);
            check("one_outstanding", mem_pend, 0);
        end
        if (prev_stall && !redir) begin
            check("hold_vld", s_fd_valid, 1);
            check("hold_no_req", s_req_valid, 0);
        end
        if (s_fd_valid) begin
            check("fd_pc", s_fd_pc, exp_pc);
            check("fd_instr", s_fd_instr, mem_fn(exp_pc));
        end

        if (redir) begin
            exp_pc = tgt & ~64'd3;
        end else if (s_fd_valid && fdr) begin
            exp_pc  = exp_pc + 64'd4;
            exp_cnt = exp_cnt + 32'd1;
        end
        prev_stall = s_fd_valid && !fdr && !redir;

        if (imem_rsp_valid_i) mem_pend = 1'b0;
        else if (mem_pend && mem_lat > 0) mem_lat--;
        if (s_req_valid && rdy) begin
            mem_pend = 1'b1;
            mem_addr = s_req_addr;
            mem_lat  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
        end
        if (w_rsp_valid) w_pend = 1'b0;
        if (w_req_valid) begin
            w_pend = 1'b1;
            w_addr = w_req_addr;
            if (w_seen < 2) w_addrs[w_seen] = w_req_addr;
            w_seen++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input int dly);
        if (dly > 0) #(dly);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h1234;
        imem_rsp_valid_i = 1'b1;
        imem_req_ready_i = 1'b1;
        fd_ready_i       = 1'b1;
        w_rsp_valid      = 1'b1;
        reset_ni         = 1'b0;
        #1;
        check("rst_req_vld", imem_req_valid_o, 0);
        check("rst_fd_vld", fd_valid_o, 0);
        check("rst_flush", fd_flush_o, 0);
        check("rst_count", fetched_count_o, 0);
        check("rst_addr", imem_req_addr_o, 64'h0);
        check("rst_wrap_addr", w_req_addr, WRAP_PC);
        mem_pend   = 1'b0;
        w_pend     = 1'b0;
        w_seen     = 0;
        exp_pc     = 64'h0;
        exp_cnt    = 32'd0;
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        redirect_valid_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        w_rsp_valid      = 1'b0;
        reset_ni         = 1'b1;
    endtask

    logic [31:0] held_instr;

    initial begin
        reset_ni         = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 64'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        fd_ready_i       = 1'b0;
        w_rsp_valid      = 1'b0;
        w_rsp_data       = 32'h0;
        mem_addr         = 64'h0;
        w_addr           = 64'h0;
        mem_lat          = 0;
        lat_fixed        = 0;
        held_instr       = 32'h0;
        @(negedge clk);

        // Streaming at peak rate, plus the wrapping-reset instance alongside
        apply_reset(0);
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, 64'h0, 1'b1, 1'b1);
            if (c == 0) check("t1_idle", s_req_valid, 0);
            if (c == 1 || c == 3 || c == 5) begin
                check("t1_req_vld", s_req_valid, 1);
                check("t1_req_addr", s_req_addr, 64'(2 * (c - 1)));
            end
            if (c == 2 || c == 4 || c == 6) begin
                check("t1_fd_vld", s_fd_valid, 1);
                check("t1_fd_pc", s_fd_pc, 64'(2 * (c - 2)));
            end
            if (c == 2) begin
                check("wrap_fd_vld", w_s_fd_valid, 1);
                check("wrap_fd_pc", w_s_fd_pc, WRAP_PC);
                check("wrap_fd_instr", w_s_fd_instr, mem_fn(WRAP_PC));
                check("wrap_flush", w_fd_flush, 0);
            end
            if (c == 7) begin
                check("t1_count", s_count, 3);
                check("wrap_count", w_s_count, 3);
            end
        end
        check("wrap_req0", w_addrs[0], WRAP_PC);
        check("wrap_req1", w_addrs[1], 64'h0);

        // FD back-pressure holds the second instruction for four cycles
        apply_reset(0);
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 64'h0, !(c >= 4 && c <= 7), 1'b1);
            if (c == 4) begin
                held_instr = s_fd_instr;
                check("t2_first_vld", s_fd_valid, 1);
            end
            if (c >= 5 && c <= 7) begin
                check("t2_hold_vld", s_fd_valid, 1);
                check("t2_hold_pc", s_fd_pc, 64'h4);
                check("t2_hold_instr", s_fd_instr, held_instr);
                check("t2_hold_noreq", s_req_valid, 0);
            end
            if (c == 8) check("t2_cnt_before", s_count, 1);
            if (c == 9) check("t2_cnt_after", s_count, 2);
        end

        // Redirect in WAIT; the stale response lands three cycles later
        lat_fixed = 3;
        apply_reset(0);
        for (int c = 0; c < 7; c++) begin
            tick(c == 2, 64'h1002, 1'b1, 1'b1);
            if (c == 2) check("t3_flush_on", s_flush, 1);
            if (c == 3) check("t3_flush_off", s_flush, 0);
            if (c == 5) check("t3_stale_drop", s_fd_valid, 0);
            if (c == 6) begin
                check("t3_req_vld", s_req_valid, 1);
                check("t3_req_addr", s_req_addr, 64'h1000);
            end
        end

        // Redirect in REQ with ready high, then redirect in HOLD
        lat_fixed = 0;
        apply_reset(0);
        for (int c = 0; c < 6; c++) begin
            tick(c == 1 || c == 4, (c == 1) ? 64'h500 : 64'h200, c != 3, 1'b1);
            if (c == 1) check("t4_req_masked", s_req_valid, 0);
            if (c == 2) check("t4_req_addr_a", s_req_addr, 64'h500);
            if (c == 3) check("t4_stall_vld", s_fd_valid, 1);
            if (c == 4) check("t4_hold_drop", s_fd_valid, 0);
            if (c == 5) begin
                check("t4_req_addr_b", s_req_addr, 64'h200);
                check("t4_count", s_count, 0);
            end
        end

        // Redirects while waiting for a stale response: last one wins
        lat_fixed = 3;
        apply_reset(0);
        for (int c = 0; c < 7; c++) begin
            tick(c >= 2 && c <= 4, (c == 2) ? 64'h100 : (c == 3) ? 64'h300 : 64'h400, 1'b1, 1'b1);
            if (c == 5) check("t5_stale_drop", s_fd_valid, 0);
            if (c == 6) begin
                check("t5_req_vld", s_req_valid, 1);
                check("t5_req_addr", s_req_addr, 64'h400);
            end
        end

        // Asynchronous reset in the middle of a WAIT
        lat_fixed = 0;
        apply_reset(0);
        for (int c = 0; c < 5; c++) begin
            if (c == 3) lat_fixed = 3;
            tick(1'b0, 64'h0, 1'b1, 1'b1);
            if (c == 4) check("t6_count_pre", s_count, 1);
        end
        apply_reset(2);
        lat_fixed = 0;
        for (int c = 0; c < 2; c++) begin
            tick(1'b0, 64'h0, 1'b1, 1'b1);
            if (c == 1) check("t6_restart_addr", s_req_addr, 64'h0);
        end

        // Random traffic against the model
        lat_fixed = -1;
        apply_reset(0);
        for (int c = 0; c < 3000; c++) begin
            logic        r_redir;
            logic [63:0] r_tgt;
            r_redir = ($urandom_range(0, 7) == 0);
            r_tgt   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r_tgt = WRAP_PC - 64'($urandom_range(0, 16));
            tick(r_redir, r_tgt, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end
        check("rand_progress", exp_cnt > 32'd100, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer for the pipelined RISC-V core. It owns the 64-bit PC and issues one instruction-memory request at a time. Each returned instruction is presented to the FD pipeline register over a valid/ready handshake. Branch/jump redirects from later stages kill in-flight or buffered wrong-path fetches and flush FD.

Parameters:
ResetPc, 64'h0000_0000_0000_0000, PC fetched first after reset; bits [1:0] must be 0.
CountWidth, 32, width of delivered-instruction counter.

Ports:
clk_i  input  1  clock, rising edge.
reset_ni  input  1  asynchronous active-low reset.
redirect_valid_i  input  1  redirect request from EX/branch unit, single cycle.
redirect_pc_i  input  64  redirect target; bits [1:0] ignored (treated as 0).
imem_req_valid_o  output  1  instruction-memory request valid.
imem_req_addr_o  output  64  request address (= current PC).
imem_req_ready_i  input  1  memory accepts request.
imem_rsp_valid_i  input  1  response valid, exactly one per accepted request, latency >=1 cycle, no back-pressure.
imem_rsp_data_i  input  32  fetched instruction.
fd_valid_o  output  1  instruction valid toward FD register.
fd_instruction_o  output  32  instruction toward FD.
fd_pc_o  output  64  PC of that instruction.
fd_ready_i  input  1  FD register ready.
fd_flush_o  output  1  flush to FD register (its pipeline_flush).
fetched_count_o  output  CountWidth  instructions delivered (fd_valid_o & fd_ready_i), wraps.

Behaviour:
- Reset (async, reset_ni low): state=IDLE, pc_q=ResetPc, hold buffer cleared, count=0. All valid outputs and fd_flush_o are 0 while in reset.
- fd_flush_o = redirect_valid_i, combinational, in every state after reset.
- Redirect priority: a redirect overrides every other event in the same cycle.
  - pc_q <= {redirect_pc_i[63:2],2'b00}.
  - No FD handshake and no counter increment occur that cycle: fd_valid_o forced 0.
- Otherwise the PC advances as pc_q + 4 modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- At most one outstanding memory request.
- States:
  - IDLE: all outputs idle; next cycle -> REQ.
  - REQ: imem_req_valid_o=1, addr=pc_q.
    - Redirect: req_valid forced 0; update pc; stay REQ.
    - Else imem_req_ready_i -> WAIT.
  - WAIT: fd_valid_o=imem_rsp_valid_i, fd_instruction_o=imem_rsp_data_i, fd_pc_o=pc_q (pass-through, zero added latency).
    - Redirect with rsp_valid: drop the response -> REQ.
    - Redirect without rsp_valid -> KILL.
    - rsp_valid & fd_ready_i: pc+=4, count++ -> REQ.
    - rsp_valid & !fd_ready_i: capture data+pc into hold buffer -> HOLD.
  - HOLD: fd_valid_o=1 from buffer; data and pc stable until accepted.
    - Redirect: discard buffer -> REQ.
    - fd_ready_i: pc+=4, count++ -> REQ.
  - KILL: outputs idle; wait for the stale response.
    - imem_rsp_valid_i: discard -> REQ.
    - Further redirects update pc_q (last wins); stay KILL.
    - Redirect coinciding with the stale response: discard it, take the new pc -> REQ.
- fd_* outputs are don't-care when fd_valid_o=0, except fd_pc_o, which always shows pc_q or the buffered pc.
- Peak throughput: one instruction per 2 cycles with single-cycle-ready, 1-cycle-latency memory.
- Reset asserted mid-operation abandons any outstanding request. The memory model must be reset together with this block.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [2:0] fetch_state_t {IDLE, REQ, WAIT, HOLD, KILL}.
  - localparam INSTR_BYTES=4.
  - typedef logic [63:0] pc_t.
- No sub-module. The hold buffer (valid, 32b instruction, 64b pc) and the counter are inline. FD_pipeline is instantiated beside, not inside, this block.

Test Plan:
- Reset release, memory ready=1, latency 1, fd_ready_i=1 -> requests to 0x0, 0x4, 0x8 on cycles 1, 3, 5; fd_valid_o on cycles 2, 4, 6 with pc 0x0/0x4/0x8; fetched_count_o=3.
- fd_ready_i held 0 for 4 cycles when response 0x00A00093 arrives -> HOLD; fd_valid_o stays 1 with constant data/pc=0x4; no new request; count increments once when ready rises.
- Redirect to 0x1002 during WAIT, response arrives 3 cycles later -> response discarded (fd_valid_o=0); fd_flush_o pulses 1 cycle; next request addr 0x1000.
- Redirect in HOLD to 0x200 -> buffer dropped, no count increment, next request 0x200; redirect in REQ with req_ready=1 -> no request issued that cycle.
- Two redirects (0x300 then 0x400) while in KILL -> first request after stale response is 0x400.
- ResetPc=64'hFFFF_FFFF_FFFF_FFFC -> second request at 0x0; async reset asserted mid-WAIT -> outputs 0 immediately, restart at ResetPc.
